// File: rtl/core_seq_ctrl_if.sv
// Signal bundle between core_seq_ctrl and its environment: software commands,
// the embedded core's control/data lines and the hardware-register readback.
interface core_seq_ctrl_if #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 32
);
   // Commands are levels; each 0->1 transition is one request. done_pulse is a
   // single-cycle strobe marking that result_hi/result_lo hold a fresh readback.
   logic                    cmd_start;
   logic                    cmd_step;
   logic                    cmd_read;
   logic                    cmd_abort;
   logic [CNT_WIDTH-1:0]    timeout_limit;
   logic                    core_halted;
   logic [DATA_WIDTH-1:0]   core_data;
   logic                    core_rst;
   logic                    core_en;
   logic                    core_flag;
   logic                    busy;
   logic                    done_pulse;
   logic [CNT_WIDTH-1:0]    cycles;
   logic [DATA_WIDTH/2-1:0] result_hi;
   logic [DATA_WIDTH/2-1:0] result_lo;
   logic [31:0]             status;

   modport master (
      output cmd_start, cmd_step, cmd_read, cmd_abort, timeout_limit, core_halted, core_data,
      input  core_rst, core_en, core_flag, busy, done_pulse, cycles, result_hi, result_lo, status
   );

   modport slave (
      input  cmd_start, cmd_step, cmd_read, cmd_abort, timeout_limit, core_halted, core_data,
      output core_rst, core_en, core_flag, busy, done_pulse, cycles, result_hi, result_lo, status
   );
endinterface

// File: rtl/core_seq_ctrl.sv
// Registered sequencer for the embedded core: reset release, free run, single
// step, halt/timeout detection and latched result readback.
module core_seq_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 32,
   parameter int READ_LAT   = 2
) (
   input logic            clk,
   input logic            reset,
   core_seq_ctrl_if.slave bus
);
   localparam int         HALF    = DATA_WIDTH / 2;
   localparam logic [3:0] RD_LAST = 4'(READ_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_STEP    = 3'd2,
      S_PAUSE   = 3'd3,
      S_HALTED  = 3'd4,
      S_READ    = 3'd5,
      S_TIMEOUT = 3'd6
   } state_t;

   state_t               state, state_nxt, ret_state, ret_nxt;
   logic [3:0]           cmd_now, cmd_d1, rise;
   logic                 hist_ok;
   logic                 ev_abort, ev_start, ev_step, ev_read;
   logic                 restart, restart_nxt;
   logic [3:0]           rd_cnt;
   logic                 timeout_err, err_nxt, halt_seen, halt_nxt;
   logic                 clr_cycles, latch, limit_hit;
   logic                 rst_nxt, en_nxt;
   logic [7:0]           rb_cnt;
   logic [CNT_WIDTH-1:0] cycles_q;
   logic [HALF-1:0]      result_hi_q, result_lo_q;
   logic                 done_q, core_rst_q, core_en_q, core_flag_q, busy_q;

   // hist_ok masks the first cycle after reset so a level held through reset never fires.
   assign cmd_now  = {bus.cmd_abort, bus.cmd_start, bus.cmd_step, bus.cmd_read};
   assign rise     = hist_ok ? (cmd_now & ~cmd_d1) : 4'b0000;
   assign ev_abort = rise[3];
   assign ev_start = rise[2] & ~rise[3];
   assign ev_step  = rise[1] & ~|rise[3:2];
   assign ev_read  = rise[0] & ~|rise[3:1];

   assign limit_hit = (bus.timeout_limit != '0) &&
                      (cycles_q == bus.timeout_limit - CNT_WIDTH'(1));

   always_comb begin
      state_nxt   = state;
      ret_nxt     = ret_state;
      restart_nxt = 1'b0;
      clr_cycles  = 1'b0;
      latch       = 1'b0;
      err_nxt     = timeout_err;
      halt_nxt    = halt_seen;
      if (ev_abort) begin
         state_nxt = S_IDLE;
         err_nxt   = 1'b0;
         halt_nxt  = 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ev_start) begin
                  state_nxt  = S_RUN;
                  clr_cycles = 1'b1;
               end else if (ev_step) begin
                  state_nxt  = S_STEP;
                  clr_cycles = 1'b1;
               end else if (ev_read) begin
                  state_nxt = S_READ;
                  ret_nxt   = S_IDLE;
               end
            end
            // The restart cycle holds the core in reset, so halt/timeout are not evaluated.
            S_RUN: begin
               if (!restart) begin
                  if (bus.core_halted) begin
                     state_nxt = S_HALTED;
                     halt_nxt  = 1'b1;
                  end else if (limit_hit) begin
                     state_nxt = S_TIMEOUT;
                     err_nxt   = 1'b1;
                  end
               end
            end
            S_STEP: begin
               if (bus.core_halted) begin
                  state_nxt = S_HALTED;
                  halt_nxt  = 1'b1;
               end else begin
                  state_nxt = S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (ev_start) begin
                  state_nxt = S_RUN;
               end else if (ev_step) begin
                  state_nxt = S_STEP;
               end else if (ev_read) begin
                  state_nxt = S_READ;
                  ret_nxt   = S_PAUSE;
               end
            end
            S_HALTED: begin
               if (ev_start) begin
                  state_nxt   = S_RUN;
                  clr_cycles  = 1'b1;
                  restart_nxt = 1'b1;
               end else if (ev_read) begin
                  state_nxt = S_READ;
                  ret_nxt   = S_HALTED;
               end
            end
            S_READ: begin
               if (rd_cnt == RD_LAST) begin
                  latch     = 1'b1;
                  state_nxt = ret_state;
               end
            end
            S_TIMEOUT: begin
               if (ev_read) begin
                  state_nxt = S_READ;
                  ret_nxt   = S_TIMEOUT;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end

      rst_nxt = 1'b0;
      en_nxt  = 1'b0;
      case (state_nxt)
         S_IDLE:  rst_nxt = 1'b1;
         S_RUN: begin
            rst_nxt = restart_nxt;
            en_nxt  = ~restart_nxt;
         end
         S_STEP:  en_nxt  = 1'b1;
         S_READ:  rst_nxt = (ret_nxt == S_IDLE);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         ret_state   <= S_IDLE;
         cmd_d1      <= 4'b0000;
         hist_ok     <= 1'b0;
         restart     <= 1'b0;
         rd_cnt      <= 4'd0;
         timeout_err <= 1'b0;
         halt_seen   <= 1'b0;
         rb_cnt      <= 8'd0;
         cycles_q    <= '0;
         result_hi_q <= '0;
         result_lo_q <= '0;
         done_q      <= 1'b0;
         core_rst_q  <= 1'b1;
         core_en_q   <= 1'b0;
         core_flag_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         ret_state   <= ret_nxt;
         cmd_d1      <= cmd_now;
         hist_ok     <= 1'b1;
         restart     <= restart_nxt;
         rd_cnt      <= (state == S_READ && state_nxt == S_READ) ? rd_cnt + 4'd1 : 4'd0;
         timeout_err <= err_nxt;
         halt_seen   <= halt_nxt;
         // cycles counts enabled core cycles and sticks at all-ones.
         if (clr_cycles) begin
            cycles_q <= '0;
         end else if (core_en_q && (cycles_q != '1)) begin
            cycles_q <= cycles_q + CNT_WIDTH'(1);
         end
         done_q <= latch;
         if (latch) begin
            result_hi_q <= bus.core_data[DATA_WIDTH-1:HALF];
            result_lo_q <= bus.core_data[HALF-1:0];
            rb_cnt      <= rb_cnt + 8'd1;
         end
         core_rst_q  <= rst_nxt;
         core_en_q   <= en_nxt;
         core_flag_q <= (state_nxt == S_READ);
         busy_q      <= (state_nxt == S_RUN) || (state_nxt == S_STEP);
      end
   end

   assign bus.core_rst   = core_rst_q;
   assign bus.core_en    = core_en_q;
   assign bus.core_flag  = core_flag_q;
   assign bus.busy       = busy_q;
   assign bus.done_pulse = done_q;
   assign bus.cycles     = cycles_q;
   assign bus.result_hi  = result_hi_q;
   assign bus.result_lo  = result_lo_q;
   assign bus.status     = {16'h0000, rb_cnt, 2'b00, halt_seen, timeout_err, busy_q, state};
endmodule
